// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the scoreboarded register bank
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);
  logic                  regWrite;
  logic [AW-1:0]         a3;
  logic [XLEN-1:0]       wd3;
  logic [NREAD*AW-1:0]   ra;
  logic [NREAD*XLEN-1:0] rd;
  logic [NREAD-1:0]      rd_busy;
  logic                  rsv;
  logic [AW-1:0]         rsv_addr;
  logic                  flush;
  logic [AW:0]           busy_cnt;
  modport master (output regWrite, a3, wd3, ra, rsv, rsv_addr, flush, input rd, rd_busy, busy_cnt);
  modport slave (input regWrite, a3, wd3, ra, rsv, rsv_addr, flush, output rd, rd_busy, busy_cnt);
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register bank with async reads, write bypass and per-register busy scoreboard
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt;
  logic             we, rv;
  function automatic logic ok(input logic [AW-1:0] a);
    return a != '0 && int'(a) < NREGS;
  endfunction
  assign we = bus.regWrite && ok(bus.a3);
  assign rv = bus.rsv && ok(bus.rsv_addr);
  // reserve is applied after the write release so a same-edge new producer keeps the bit set
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we) begin
      regs_d[bus.a3] = bus.wd3;
      busy_d[bus.a3] = 1'b0;
    end
    if (rv) busy_d[bus.rsv_addr] = 1'b1;
    if (bus.flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  always_comb begin
    cnt = '0;
    for (int j = 0; j < NREGS; j++) cnt = cnt + (AW+1)'(busy_q[j]);
  end
  assign bus.busy_cnt = cnt;
  // bypass is gated by rst_n so reads stay zero for the whole reset window
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          v, hit;
    assign a   = bus.ra[i*AW +: AW];
    assign v   = ok(a);
    assign hit = BYPASS != 0 && rst_n && bus.regWrite && bus.a3 == a;
    assign bus.rd[i*XLEN +: XLEN] = !v ? '0 : hit ? bus.wd3 : regs_q[a];
    assign bus.rd_busy[i] = v && busy_q[a] && !hit;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven scoreboard bench for regfile_sb (BYPASS=1 and BYPASS=0 instances)
module tb_regfile_sb;
  typedef struct {
    logic we; logic [4:0] a3; logic [31:0] wd; logic [4:0] ra0, ra1;
    logic rsv; logic [4:0] raddr; logic fl;
    logic [31:0] rd0, rd1, rd1_nb; logic b0, b1; logic [5:0] cnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus ();
  regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_nb ();
  assign bus_nb.regWrite = bus.regWrite;
  assign bus_nb.a3       = bus.a3;
  assign bus_nb.wd3      = bus.wd3;
  assign bus_nb.ra       = bus.ra;
  assign bus_nb.rsv      = bus.rsv;
  assign bus_nb.rsv_addr = bus.rsv_addr;
  assign bus_nb.flush    = bus.flush;
  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));
  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t sb[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic add(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [4:0] ra0, ra1,
                     input logic rsv, input logic [4:0] raddr, input logic fl,
                     input logic [31:0] rd0, rd1, rd1_nb, input logic b0, b1, input logic [5:0] cnt);
    vec_t v;
    v = '{we, a3, wd, ra0, ra1, rsv, raddr, fl, rd0, rd1, rd1_nb, b0, b1, cnt};
    tbl.push_back(v);
  endtask
  task automatic drive(input vec_t v);
    bus.regWrite = v.we; bus.a3 = v.a3; bus.wd3 = v.wd; bus.ra = {v.ra1, v.ra0};
    bus.rsv = v.rsv; bus.rsv_addr = v.raddr; bus.flush = v.fl;
  endtask
  task automatic idle();
    bus.regWrite = 0; bus.a3 = 0; bus.wd3 = 0; bus.ra = 0; bus.rsv = 0; bus.rsv_addr = 0; bus.flush = 0;
  endtask
  initial begin
    vec_t e;
    add(1,5,32'hDEADBEEF,5,0, 0,0,0, 32'hDEADBEEF,0,0, 0,0,0);
    add(0,0,0,5,5, 0,0,0, 32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF, 0,0,0);
    add(1,0,32'h12345678,0,5, 1,0,0, 0,32'hDEADBEEF,32'hDEADBEEF, 0,0,0);
    add(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
    add(1,7,32'hA5A5A5A5,5,7, 0,0,0, 32'hDEADBEEF,32'hA5A5A5A5,0, 0,0,0);
    add(0,0,0,0,7, 0,0,0, 0,32'hA5A5A5A5,32'hA5A5A5A5, 0,0,0);
    add(0,0,0,10,7, 1,10,0, 0,32'hA5A5A5A5,32'hA5A5A5A5, 0,0,0);
    add(0,0,0,10,7, 0,0,0, 0,32'hA5A5A5A5,32'hA5A5A5A5, 1,0,1);
    add(1,10,32'h55,10,10, 0,0,0, 32'h55,32'h55,0, 0,0,1);
    add(0,0,0,10,10, 0,0,0, 32'h55,32'h55,32'h55, 0,0,0);
    add(1,3,32'h99,3,3, 1,3,0, 32'h99,32'h99,0, 0,0,0);
    add(0,0,0,3,3, 0,0,0, 32'h99,32'h99,32'h99, 1,1,1);
    add(1,3,32'h99,1,2, 1,1,0, 0,0,0, 0,0,1);
    add(0,0,0,1,2, 1,2,0, 0,0,0, 1,0,1);
    add(0,0,0,2,31, 1,31,0, 0,0,0, 1,0,2);
    add(0,0,0,31,4, 1,4,1, 0,0,0, 1,0,3);
    add(0,0,0,4,31, 0,0,0, 0,0,0, 0,0,0);
    add(0,0,0,5,3, 0,0,0, 32'hDEADBEEF,32'h99,32'h99, 0,0,0);
    add(0,0,0,7,10, 0,0,0, 32'hA5A5A5A5,32'h55,32'h55, 0,0,0);
    add(0,0,0,6,0, 1,6,0, 0,0,0, 0,0,0);
    add(0,0,0,6,0, 1,6,0, 0,0,0, 1,0,1);
    add(0,0,0,6,0, 0,0,0, 0,0,0, 1,0,1);
    add(1,6,32'h1,6,0, 0,0,0, 32'h1,0,0, 0,0,1);
    add(0,0,0,6,0, 0,0,0, 32'h1,0,0, 0,0,0);
    idle();
    bus.ra = {5'd5, 5'd7};
    #1;
    chk("reset_rd0", bus.rd[31:0], 0);
    chk("reset_rd1", bus.rd[63:32], 0);
    chk("reset_busy", 32'(bus.rd_busy), 0);
    chk("reset_cnt", 32'(bus.busy_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[k]) begin
      @(posedge clk);
      #1 drive(tbl[k]);
      sb.push_back(tbl[k]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_rd0", k), bus.rd[31:0], e.rd0);
      chk($sformatf("v%0d_rd1", k), bus.rd[63:32], e.rd1);
      chk($sformatf("v%0d_rd1_nobypass", k), bus_nb.rd[63:32], e.rd1_nb);
      chk($sformatf("v%0d_busy0", k), 32'(bus.rd_busy[0]), 32'(e.b0));
      chk($sformatf("v%0d_busy1", k), 32'(bus.rd_busy[1]), 32'(e.b1));
      chk($sformatf("v%0d_cnt", k), 32'(bus.busy_cnt), 32'(e.cnt));
    end
    @(posedge clk);
    #1 idle();
    bus.rsv = 1; bus.rsv_addr = 9;
    @(posedge clk);
    #1 idle();
    bus.ra = {5'd5, 5'd9};
    @(negedge clk);
    chk("pre_rst_busy9", 32'(bus.rd_busy[0]), 1);
    chk("pre_rst_cnt", 32'(bus.busy_cnt), 1);
    #2 bus.regWrite = 1; bus.a3 = 5; bus.wd3 = 32'h77; bus.ra = {5'd9, 5'd5};
    bus.rsv = 1; bus.rsv_addr = 12;
    #1 chk("pre_rst_bypass", bus.rd[31:0], 32'h77);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd0", bus.rd[31:0], 0);
    chk("midrst_busy1", 32'(bus.rd_busy[1]), 0);
    chk("midrst_cnt", 32'(bus.busy_cnt), 0);
    @(posedge clk);
    #1 chk("inrst_edge_rd0", bus.rd[31:0], 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    bus.ra = {5'd12, 5'd5};
    #1;
    chk("post_rst_rd5", bus.rd[31:0], 0);
    chk("post_rst_cnt", 32'(bus.busy_cnt), 0);
    bus.regWrite = 1; bus.a3 = 5; bus.wd3 = 32'h1234; bus.rsv = 1; bus.rsv_addr = 12;
    @(posedge clk);
    #1 idle();
    bus.ra = {5'd12, 5'd5};
    #1;
    chk("first_edge_rd5", bus.rd[31:0], 32'h1234);
    chk("first_edge_busy12", 32'(bus.rd_busy[1]), 1);
    chk("first_edge_cnt", 32'(bus.busy_cnt), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
